// File: rtl/vga_scanout.sv
// Purpose: raster-scans the displayed frame buffer and drives 640x480@60 VGA sync/colour, issuing swap at vblank start.
// Latency: colour/hsync/vsync reach the pins 2 clk edges after the counters; read_addr, vblank and swap are combinational.
// Backpressure: none; free-running pixel clock, and swap requests are held pending until the next swap point.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [18:0] read_addr,
  input  logic        read_data,
  input  logic        swap_req,
  output logic        swap,
  output logic        vblank,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  h;
  logic [9:0]  v;
  logic [18:0] addr;
  logic        pending;

  logic        h_wrap;
  logic        frame_wrap;
  logic        active;
  logic        hsync_pre;
  logic        vsync_pre;
  logic        swap_point;

  logic        active_d1;
  logic        hsync_d1;
  logic        vsync_d1;
  logic [3:0]  colour;

  assign h_wrap     = (h == H_LAST);
  assign frame_wrap = h_wrap && (v == V_LAST);
  assign active     = (h < H_VIS) && (v < V_VIS);
  assign hsync_pre  = !((h >= HS_START) && (h < HS_END));
  assign vsync_pre  = !((v >= VS_START) && (v < VS_END));
  assign swap_point = (h == 10'd0) && (v == V_VIS);

  assign read_addr  = addr;
  assign vblank     = (v >= V_VIS);
  assign swap       = swap_point && (pending || swap_req);

  // Address is a running count of active pixels, avoiding a y*640 multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h    <= '0;
      v    <= '0;
      addr <= '0;
    end else begin
      h <= h_wrap ? 10'd0 : h + 10'd1;
      if (h_wrap) begin
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end
      if (frame_wrap) begin
        addr <= '0;
      end else if (active) begin
        addr <= addr + 19'd1;
      end
    end
  end

  // A request on the swap point itself is served combinationally, so pending only covers earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (swap_point) begin
      pending <= 1'b0;
    end else if (swap_req) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_d1 <= 1'b0;
      hsync_d1  <= 1'b1;
      vsync_d1  <= 1'b1;
      colour    <= 4'h0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else begin
      active_d1 <= active;
      hsync_d1  <= hsync_pre;
      vsync_d1  <= vsync_pre;
      colour    <= {4{read_data & active_d1}};
      hsync     <= hsync_d1;
      vsync     <= vsync_d1;
    end
  end

  assign vga_r = colour;
  assign vga_g = colour;
  assign vga_b = colour;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-timing instance checked every cycle against a position-based model,
// plus a default 640x480 instance pinned with literal line-timing values.
module tb_vga_scanout;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 15
  localparam int VT = VV + VF + VS + VB;   // 8

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_data = 1'b0;
  logic        swap_req = 1'b0;
  logic        rd_full = 1'b1;
  logic        req_full = 1'b0;

  logic [18:0] rd_addr, rd_addr_f;
  logic        swap, swap_f, vblank, vblank_f;
  logic        hsync, hsync_f, vsync, vsync_f;
  logic [3:0]  vga_r, vga_g, vga_b, vga_r_f, vga_g_f, vga_b_f;

  int n_cmp = 0;
  int n_err = 0;
  int p = 0;
  int phase = 0;
  bit m_pending = 1'b0;
  int req_q[$];
  int swaps_seen[$];
  int swaps_exp[$];
  logic [18:0] a_s;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_addr(rd_addr), .read_data(read_data),
    .swap_req(swap_req), .swap(swap), .vblank(vblank), .hsync(hsync),
    .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  vga_scanout dut_full (
    .clk(clk), .rst_n(rst_n), .read_addr(rd_addr_f), .read_data(rd_full),
    .swap_req(req_full), .swap(swap_f), .vblank(vblank_f), .hsync(hsync_f),
    .vsync(vsync_f), .vga_r(vga_r_f), .vga_g(vga_g_f), .vga_b(vga_b_f)
  );

  always #5 clk = ~clk;

  function automatic bit pix(int a);
    int x, y;
    x = a % HV;
    y = a / HV;
    return (((x + y) % 2) == 1) || ((a % 5) == 0);
  endfunction

  // Number of active pixels already visited in the frame before position q.
  function automatic int exp_addr(int q);
    int h, v;
    h = q % HT;
    v = (q / HT) % VT;
    if (v < VV) return v * HV + ((h < HV) ? h : HV);
    return VV * HV;
  endfunction

  // Frame buffer stand-in: data for the address seen this cycle arrives after the next edge.
  initial begin
    forever begin
      @(negedge clk);
      a_s = rd_addr;
      @(posedge clk);
      #1 read_data = pix(int'(a_s));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at p=%0d: got %0d, want %0d", nm, p, act, exp);
    end
  endtask

  task automatic reset_chk();
    chk("rst_addr", rd_addr, 0);
    chk("rst_swap", swap, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_vblank", vblank, 0);
    chk("rst_col", {vga_r, vga_g, vga_b}, 0);
    chk("rst_addr_full", rd_addr_f, 0);
    chk("rst_hsync_full", hsync_f, 1);
    chk("rst_col_full", {vga_r_f, vga_g_f, vga_b_f}, 0);
  endtask

  task automatic pin_small();
    if (p == 2)   chk("pin_col_p2", vga_r, 15);
    if (p == 4)   chk("pin_col_p4", vga_r, 0);
    if (p == 11)  chk("pin_hs_p11", hsync, 1);
    if (p == 12)  chk("pin_hs_p12", hsync, 0);
    if (p == 14)  chk("pin_hs_p14", hsync, 0);
    if (p == 15)  chk("pin_hs_p15", hsync, 1);
    if (p == 15)  chk("pin_addr_line1", rd_addr, 8);
    if (p == 52)  chk("pin_addr_last", rd_addr, 31);
    if (p == 53)  chk("pin_addr_total", rd_addr, 32);
    if (p == 120) chk("pin_addr_wrap", rd_addr, 0);
    if (p == 59)  chk("pin_vblank_p59", vblank, 0);
    if (p == 60)  chk("pin_vblank_p60", vblank, 1);
    if (p == 76)  chk("pin_vs_p76", vsync, 1);
    if (p == 77)  chk("pin_vs_p77", vsync, 0);
    if (p == 106) chk("pin_vs_p106", vsync, 0);
    if (p == 107) chk("pin_vs_p107", vsync, 1);
  endtask

  task automatic pin_full();
    if (p == 2)    chk("full_col_p2", vga_r_f, 15);
    if (p == 641)  chk("full_col_p641", vga_g_f, 15);
    if (p == 642)  chk("full_col_p642", vga_b_f, 0);
    if (p == 639)  chk("full_addr_639", rd_addr_f, 639);
    if (p == 800)  chk("full_addr_line1", rd_addr_f, 640);
    if (p == 1439) chk("full_addr_1279", rd_addr_f, 1279);
    if (p == 657)  chk("full_hs_p657", hsync_f, 1);
    if (p == 658)  chk("full_hs_p658", hsync_f, 0);
    if (p == 753)  chk("full_hs_p753", hsync_f, 0);
    if (p == 754)  chk("full_hs_p754", hsync_f, 1);
    if (p == 1457) chk("full_hs_p1457", hsync_f, 1);
    if (p == 1458) chk("full_hs_p1458", hsync_f, 0);
    if (p == 1000) chk("full_vblank", vblank_f, 0);
    if (p == 1000) chk("full_vsync", vsync_f, 1);
    if (p == 1000) chk("full_swap", swap_f, 0);
  endtask

  // One cycle: drive swap_req for position p, check everything, advance to the next negedge.
  task automatic step_check();
    int h, v, q, hq, vq, ecol;
    bit req, sp, esw, ehs, evs;
    h = p % HT;
    v = (p / HT) % VT;
    req = 1'b0;
    foreach (req_q[i]) if (req_q[i] == p) req = 1'b1;
    swap_req = req;
    #1;
    sp  = (h == 0) && (v == VV);
    esw = sp && (m_pending || req);
    chk("swap", swap, esw);
    if (swap) swaps_seen.push_back(p);
    if (sp) m_pending = 1'b0;
    else if (req) m_pending = 1'b1;
    chk("read_addr", rd_addr, exp_addr(p));
    chk("vblank", vblank, v >= VV);
    ecol = 0;
    ehs = 1'b1;
    evs = 1'b1;
    if (p >= 2) begin
      q  = p - 2;
      hq = q % HT;
      vq = (q / HT) % VT;
      if (hq < HV && vq < VV && pix(vq * HV + hq)) ecol = 15;
      ehs = !(hq >= HV + HF && hq < HV + HF + HS);
      evs = !(vq >= VV + VF && vq < VV + VF + VS);
    end
    chk("vga_r", vga_r, ecol);
    chk("vga_g", vga_g, ecol);
    chk("vga_b", vga_b, ecol);
    chk("hsync", hsync, ehs);
    chk("vsync", vsync, evs);
    if (phase == 0) pin_small();
    else pin_full();
    @(negedge clk);
    p++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_chk();
    req_q = '{35, 121, 138, 172, 420, 541, 725};
    rst_n = 1'b1;
    p = 0;
    m_pending = 1'b0;
    phase = 0;
    repeat (740) step_check();

    // Mid-line reset with a request still pending; it must be dropped.
    swap_req = 1'b0;
    rst_n = 1'b0;
    #1 reset_chk();
    repeat (3) @(negedge clk);
    reset_chk();

    swaps_exp = '{60, 180, 420, 660};
    chk("swap_count", swaps_seen.size(), swaps_exp.size());
    foreach (swaps_exp[i]) begin
      if (i < swaps_seen.size()) chk("swap_pos", swaps_seen[i], swaps_exp[i]);
    end

    swaps_seen.delete();
    req_q.delete();
    rst_n = 1'b1;
    p = 0;
    m_pending = 1'b0;
    phase = 1;
    repeat (1500) step_check();
    swap_req = 1'b0;
    chk("swap_after_reset", swaps_seen.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
